// File: rtl/maze_probe.sv
// Wall-collision responder: probes the two tile-map cells a sprite's leading
// edge would enter after a one-pixel step and answers with a one-cycle strobe.
module maze_probe #(
    parameter int SPRITE_W   = 16,
    parameter int TILE_SHIFT = 3,
    parameter int MAP_COLS   = 80,
    parameter int MAP_ROWS   = 60,
    parameter int SCR_W      = 640,
    parameter int SCR_H      = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [9:0]  req_x,
    input  logic [8:0]  req_y,
    input  logic [1:0]  req_dir,
    output logic [12:0] map_addr,
    input  logic        map_data,
    output logic        resp_valid,
    output logic        resp_free
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        WAIT = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [12:0] addr_a_q, addr_a_d;
    logic [12:0] addr_b_q, addr_b_d;
    logic        oob_a_q, oob_a_d;
    logic        oob_b_q, oob_b_d;
    logic        wall_a_q, wall_a_d;
    logic        wall_b_q, wall_b_d;
    logic        resp_free_q, resp_free_d;

    logic [10:0] x0, y0, ww;
    logic [10:0] ax, ay, bx, by;

    // Coordinates are 11-bit two's complement; bit 10 set means negative.
    function automatic logic out_of_bounds(input logic [10:0] px, input logic [10:0] py);
        return px[10] || py[10]
            || (px >= 11'(SCR_W)) || (py >= 11'(SCR_H))
            || ((px >> TILE_SHIFT) >= 11'(MAP_COLS))
            || ((py >> TILE_SHIFT) >= 11'(MAP_ROWS));
    endfunction

    function automatic logic [12:0] tile_addr(input logic [10:0] px, input logic [10:0] py);
        logic [12:0] row;
        logic [12:0] col;
        row = 13'(py >> TILE_SHIFT);
        col = 13'(px >> TILE_SHIFT);
        return row * 13'(MAP_COLS) + col;
    endfunction

    always_comb begin
        x0 = {1'b0, req_x};
        y0 = {2'b00, req_y};
        ww = 11'(SPRITE_W);
        ax = x0;
        ay = y0;
        bx = x0;
        by = y0;
        unique case (req_dir)
            2'b00: begin
                ax = x0;
                ay = y0 - 11'd1;
                bx = x0 + ww - 11'd1;
                by = y0 - 11'd1;
            end
            2'b01: begin
                ax = x0;
                ay = y0 + ww;
                bx = x0 + ww - 11'd1;
                by = y0 + ww;
            end
            2'b10: begin
                ax = x0 - 11'd1;
                ay = y0;
                bx = x0 - 11'd1;
                by = y0 + ww - 11'd1;
            end
            2'b11: begin
                ax = x0 + ww;
                ay = y0;
                bx = x0 + ww;
                by = y0 + ww - 11'd1;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_a_d    = addr_a_q;
        addr_b_d    = addr_b_q;
        oob_a_d     = oob_a_q;
        oob_b_d     = oob_b_q;
        wall_a_d    = wall_a_q;
        wall_b_d    = wall_b_q;
        resp_free_d = resp_free_q;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        map_addr    = 13'd0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    // Off-screen probes still issue a read, but at address 0.
                    oob_a_d  = out_of_bounds(ax, ay);
                    oob_b_d  = out_of_bounds(bx, by);
                    addr_a_d = oob_a_d ? 13'd0 : tile_addr(ax, ay);
                    addr_b_d = oob_b_d ? 13'd0 : tile_addr(bx, by);
                    state_d  = RD_A;
                end
            end
            RD_A: begin
                map_addr = addr_a_q;
                state_d  = RD_B;
            end
            RD_B: begin
                map_addr = addr_b_q;
                wall_a_d = oob_a_q | map_data;
                state_d  = WAIT;
            end
            WAIT: begin
                wall_b_d    = oob_b_q | map_data;
                resp_free_d = ~(wall_a_q | wall_b_d);
                state_d     = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_a_q    <= 13'd0;
            addr_b_q    <= 13'd0;
            oob_a_q     <= 1'b0;
            oob_b_q     <= 1'b0;
            wall_a_q    <= 1'b0;
            wall_b_q    <= 1'b0;
            resp_free_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            oob_a_q     <= oob_a_d;
            oob_b_q     <= oob_b_d;
            wall_a_q    <= wall_a_d;
            wall_b_q    <= wall_b_d;
            resp_free_q <= resp_free_d;
        end
    end

    assign resp_free = resp_free_q;

endmodule

// File: tb/tb_maze_probe.sv
// Directed bench for maze_probe: table of queries with hand-computed probe
// addresses and answers, plus back-to-back and mid-query reset sequences.
module tb_maze_probe;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_x;
    logic [8:0]  req_y;
    logic [1:0]  req_dir;
    logic [12:0] map_addr;
    logic        map_data;
    logic        resp_valid;
    logic        resp_free;

    int n_checks;
    int n_fail;

    logic map_mem [0:4799];

    typedef struct {
        logic [9:0]  x;
        logic [8:0]  y;
        logic [1:0]  dir;
        int          wall;
        logic [12:0] exp_a;
        logic [12:0] exp_b;
        logic        exp_free;
    } vec_t;

    vec_t vecs [12];

    maze_probe dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_dir    (req_dir),
        .map_addr   (map_addr),
        .map_data   (map_data),
        .resp_valid (resp_valid),
        .resp_free  (resp_free)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wall-map ROM: one-cycle read latency.
    always @(posedge clk) begin
        map_data <= (map_addr < 13'd4800) ? map_mem[map_addr] : 1'b0;
    end

    task automatic check_output(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic load_map(input int wall);
        for (int i = 0; i < 4800; i++) map_mem[i] = 1'b0;
        if (wall >= 0) map_mem[wall] = 1'b1;
    endtask

    task automatic apply_stimulus(input vec_t v, input int idx);
        int waited;
        load_map(v.wall);
        @(negedge clk);
        req_x     = v.x;
        req_y     = v.y;
        req_dir   = v.dir;
        req_valid = 1'b1;
        waited    = 0;
        while (req_ready !== 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check_output($sformatf("v%0d_ready", idx), int'(req_ready), 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_output($sformatf("v%0d_t1_addr", idx), int'(map_addr), int'(v.exp_a));
        check_output($sformatf("v%0d_t1_ready", idx), int'(req_ready), 0);
        @(posedge clk);
        #1;
        check_output($sformatf("v%0d_t2_addr", idx), int'(map_addr), int'(v.exp_b));
        check_output($sformatf("v%0d_t2_valid", idx), int'(resp_valid), 0);
        @(posedge clk);
        #1;
        check_output($sformatf("v%0d_t3_addr", idx), int'(map_addr), 0);
        check_output($sformatf("v%0d_t3_valid", idx), int'(resp_valid), 0);
        @(posedge clk);
        #1;
        check_output($sformatf("v%0d_t4_valid", idx), int'(resp_valid), 1);
        check_output($sformatf("v%0d_t4_free", idx), int'(resp_free), int'(v.exp_free));
        check_output($sformatf("v%0d_t4_addr", idx), int'(map_addr), 0);
        @(posedge clk);
        #1;
        check_output($sformatf("v%0d_t5_valid", idx), int'(resp_valid), 0);
        check_output($sformatf("v%0d_t5_ready", idx), int'(req_ready), 1);
        check_output($sformatf("v%0d_t5_free_hold", idx), int'(resp_free), int'(v.exp_free));
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        req_valid = 1'b0;
        req_x     = '0;
        req_y     = '0;
        req_dir   = '0;
        load_map(-1);

        //        x    y    dir    wall  A     B     free
        vecs[0]  = '{10'd200, 9'd146, 2'b00, -1,   13'd1465, 13'd1466, 1'b1};
        vecs[1]  = '{10'd200, 9'd146, 2'b00, 1466, 13'd1465, 13'd1466, 1'b0};
        vecs[2]  = '{10'd200, 9'd146, 2'b00, 1465, 13'd1465, 13'd1466, 1'b0};
        vecs[3]  = '{10'd0,   9'd100, 2'b10, -1,   13'd0,    13'd0,    1'b0};
        vecs[4]  = '{10'd624, 9'd100, 2'b11, -1,   13'd0,    13'd0,    1'b0};
        vecs[5]  = '{10'd100, 9'd464, 2'b01, -1,   13'd0,    13'd0,    1'b0};
        vecs[6]  = '{10'd623, 9'd100, 2'b11, -1,   13'd1039, 13'd1199, 1'b1};
        vecs[7]  = '{10'd40,  9'd40,  2'b01, -1,   13'd565,  13'd566,  1'b1};
        vecs[8]  = '{10'd80,  9'd8,   2'b10, 169,  13'd89,   13'd169,  1'b0};
        vecs[9]  = '{10'd100, 9'd0,   2'b00, -1,   13'd0,    13'd0,    1'b0};
        vecs[10] = '{10'd300, 9'd200, 2'b11, 2039, 13'd2039, 13'd2119, 1'b0};
        vecs[11] = '{10'd624, 9'd463, 2'b01, -1,   13'd4798, 13'd4799, 1'b1};

        rst = 1'b0;
        #1;
        check_output("reset_ready", int'(req_ready), 1);
        check_output("reset_addr", int'(map_addr), 0);
        check_output("reset_valid", int'(resp_valid), 0);
        check_output("reset_free", int'(resp_free), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) apply_stimulus(vecs[i], i);

        // Held req_valid: accepts five cycles apart, resp_free held in between.
        $display("[TB] back-to-back sequence");
        load_map(-1);
        @(negedge clk);
        req_x     = 10'd200;
        req_y     = 9'd146;
        req_dir   = 2'b00;
        req_valid = 1'b1;
        check_output("b2b_ready0", int'(req_ready), 1);
        @(posedge clk);
        for (int k = 1; k <= 9; k++) begin
            #1;
            check_output($sformatf("b2b_k%0d_ready", k), int'(req_ready), (k == 5) ? 1 : 0);
            check_output($sformatf("b2b_k%0d_valid", k), int'(resp_valid), (k == 4 || k == 9) ? 1 : 0);
            if (k >= 4)
                check_output($sformatf("b2b_k%0d_free", k), int'(resp_free), (k == 9) ? 0 : 1);
            if (k == 6)
                check_output("b2b_oob_addr", int'(map_addr), 0);
            if (k == 5) begin
                req_x   = 10'd0;
                req_dir = 2'b10;
            end
            if (k == 9) req_valid = 1'b0;
            @(posedge clk);
        end

        // Establish resp_free=1, then reset during RD_B.
        $display("[TB] mid-query reset sequence");
        apply_stimulus(vecs[0], 100);
        @(negedge clk);
        req_x     = 10'd200;
        req_y     = 9'd146;
        req_dir   = 2'b00;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check_output("rst_pre_addr_b", int'(map_addr), 1466);
        rst = 1'b0;
        #1;
        check_output("rst_ready", int'(req_ready), 1);
        check_output("rst_addr", int'(map_addr), 0);
        check_output("rst_valid", int'(resp_valid), 0);
        check_output("rst_free", int'(resp_free), 0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check_output($sformatf("rst_no_resp_%0d", k), int'(resp_valid), 0);
        end
        apply_stimulus(vecs[6], 101);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/maze_probe.md
# maze_probe

Wall-collision responder for the maze sprites (Pac-Man and ghosts). A mover submits its sprite's top-left position and intended direction. The block reads the two tile-map cells the sprite's leading edge would enter after a one-pixel step, then returns a one-cycle response saying whether the move is free. It sits between the movers and the wall-map ROM, and is the answering end of the per-step collision query that movers issue before changing position or direction.

## Interface
- `SPRITE_W`, 16, sprite edge length in pixels (square sprite)
- `TILE_SHIFT`, 3, log2 of tile edge in pixels (8-pixel tiles)
- `MAP_COLS`, 80, tiles per row (640 / 8)
- `MAP_ROWS`, 60, tile rows (480 / 8)
- `SCR_W`, 640, screen width in pixels
- `SCR_H`, 480, screen height in pixels

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  reset, asynchronous, active-low
- `req_valid`  in  1  query present
- `req_ready`  out  1  block idle and able to accept a query
- `req_x`  in  10  sprite top-left X
- `req_y`  in  9  sprite top-left Y
- `req_dir`  in  2  direction: 00 up (y-1), 01 down (y+1), 10 left (x-1), 11 right (x+1)
- `map_addr`  out  13  wall-map address, row*MAP_COLS+col
- `map_data`  in  1  wall bit (1 = wall), valid the cycle after `map_addr` is presented
- `resp_valid`  out  1  one-cycle response strobe
- `resp_free`  out  1  1 = move allowed; held until the next response

## Operation
- Handshake:
  - Accept on a rising `clk` edge with `req_valid && req_ready`.
  - `req_ready` = 1 only in IDLE.
  - `req_x/y/dir` are sampled at accept only.
- Probe points, with W=SPRITE_W:
  - up: (x, y-1) and (x+W-1, y-1)
  - down: (x, y+W) and (x+W-1, y+W)
  - left: (x-1, y) and (x-1, y+W-1)
  - right: (x+W, y) and (x+W, y+W-1)
- Arithmetic is 11-bit signed, so x-1 at x=0 gives -1 and no wrap occurs.
- Out of bounds: a probe with any coordinate <0, x≥SCR_W or y≥SCR_H is a wall. Its read still occurs with `map_addr`=0, and the data is ignored.
- Tile address: col = px>>TILE_SHIFT, row = py>>TILE_SHIFT, addr = row*MAP_COLS+col (13 bits, max 4799).
- `resp_free` = neither probe is a wall.
- FSM:
  - IDLE → RD_A on accept; probes are registered.
  - RD_A: `map_addr`=A → RD_B.
  - RD_B: `map_addr`=B, capture `map_data` as wall_A → WAIT.
  - WAIT: capture `map_data` as wall_B → RESP.
  - RESP: `resp_valid`=1, `resp_free` updated → IDLE.
- `map_addr` returns to 0 in IDLE, WAIT and RESP.
- Queries are never queued or dropped once accepted. A `req_valid` outside IDLE waits for `req_ready`.

## Timing
- Accept edge T:
  - `map_addr`=A during cycle T+1 and B during cycle T+2.
  - `resp_valid` high for exactly cycle T+4.
- Latency is fixed at 4 cycles, including out-of-bounds cases.
- Throughput: one query per 5 cycles. `req_ready` is high again in cycle T+5, so back-to-back accepts occur at T and T+5.
- `resp_free` changes only on the edge entering RESP.
- Reset values (asynchronous while `rst`=0):
  - state IDLE
  - `req_ready`=1
  - `map_addr`=0
  - `resp_valid`=0
  - `resp_free`=0
  - probe and wall registers 0
- Reset mid-query aborts it with no response; the first accept after `rst` rises follows normal timing.

## Test plan
- Ghost at (200,146), dir 00, map all zeros:
  - `map_addr` 1465 then 1466.
  - `resp_valid` at T+4 with `resp_free`=1.
- Same query with map bit 1466 = 1 → `resp_free`=0. Bit 1465 only = 1 → also 0.
- Boundary blocks:
  - x=0, dir 10 → `resp_free`=0.
  - x=624 (x+16=640), dir 11 → 0.
  - y=464, dir 01 → 0.
  - All at latency 4, `map_addr`=0 for the out-of-bounds probe.
- Exact-edge free: x=623, dir 11, empty map → probes at px=639, col 79 → `resp_free`=1.
- Hold `req_valid` continuously:
  - accepts at T and T+5 only; `req_ready` low during T+1..T+4.
  - `resp_free` holds between strobes.
- Assert `rst`=0 during RD_B, then release:
  - outputs take reset values immediately, no `resp_valid`.
  - next query responds 4 cycles after accept.
